// File: rtl/pulsar_phase_binner.sv
// Pulsar phase tracker with epoch/resync control and a restoring divider that folds phase into bins.
// Sample edge to bin_valid is BIN_BITS+1 edges, one result every BIN_BITS+2 cycles; no backpressure, bin_valid is a strobe.
module pulsar_phase_binner #(
    parameter int CNT_W      = 32,
    parameter int BIN_BITS   = 10,
    parameter int DIV_N      = 8,
    parameter int PERIOD_RST = 1024
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic                cfg_load,
    input  logic [CNT_W-1:0]    period_in,
    input  logic [CNT_W-1:0]    epoch_in,
    input  logic                resync_en,
    input  logic                pulse_detected,
    output logic                clk_out,
    output logic [CNT_W-1:0]    phase,
    output logic [BIN_BITS-1:0] bin_index,
    output logic [CNT_W-1:0]    bin_phase,
    output logic                bin_valid,
    output logic [CNT_W-1:0]    pulse_phase,
    output logic                pulse_seen,
    output logic                cfg_err
);

    localparam int DC_W   = (DIV_N > 1) ? $clog2(DIV_N) : 1;
    localparam int STEP_W = (BIN_BITS > 1) ? $clog2(BIN_BITS) : 1;
    localparam logic [DC_W-1:0]   DC_LAST   = DC_W'(DIV_N - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(BIN_BITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

    logic [DC_W-1:0]     div_cnt_q;
    logic                clk_out_q;

    logic [CNT_W-1:0]    period_q, period_d;
    logic [CNT_W-1:0]    phase_q, phase_d;
    logic [CNT_W-1:0]    pulse_phase_q, pulse_phase_d;
    logic                pulse_seen_q;
    logic                cfg_err_q, cfg_err_d;
    logic                cfg_ok;
    logic [CNT_W-1:0]    phase_inc;

    state_t              state_q;
    logic [CNT_W:0]      rem_q;
    logic [CNT_W-1:0]    divisor_q;
    logic [CNT_W-1:0]    sample_q;
    logic [BIN_BITS-1:0] quot_q;
    logic [STEP_W-1:0]   step_q;
    logic [BIN_BITS-1:0] bin_index_q;
    logic [CNT_W-1:0]    bin_phase_q;
    logic                bin_valid_q;

    logic [CNT_W:0]      rem_sh;
    logic                rem_ge;
    logic [CNT_W:0]      rem_nx;
    logic [BIN_BITS-1:0] quot_nx;

    // Free-running clock divider, independent of configuration.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
            clk_out_q <= 1'b0;
        end else if (div_cnt_q == DC_LAST) begin
            div_cnt_q <= '0;
            clk_out_q <= ~clk_out_q;
        end else begin
            div_cnt_q <= div_cnt_q + DC_W'(1);
        end
    end

    assign cfg_ok    = cfg_load && (period_in != '0) && (epoch_in < period_in);
    assign phase_inc = (phase_q == period_q - CNT_W'(1)) ? '0 : phase_q + CNT_W'(1);

    // A cfg_load in the same cycle masks the pulse, even if the load itself is rejected.
    always_comb begin
        period_d      = period_q;
        phase_d       = phase_inc;
        pulse_phase_d = pulse_phase_q;
        cfg_err_d     = cfg_err_q;
        if (cfg_ok) begin
            period_d  = period_in;
            phase_d   = (epoch_in == '0) ? '0 : period_in - epoch_in;
            cfg_err_d = 1'b0;
        end else if (cfg_load) begin
            cfg_err_d = 1'b1;
        end else if (pulse_detected) begin
            pulse_phase_d = phase_q;
            if (resync_en) begin
                phase_d = '0;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            period_q      <= CNT_W'(PERIOD_RST);
            phase_q       <= '0;
            pulse_phase_q <= '0;
            pulse_seen_q  <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            period_q      <= period_d;
            phase_q       <= phase_d;
            pulse_phase_q <= pulse_phase_d;
            pulse_seen_q  <= pulse_detected;
            cfg_err_q     <= cfg_err_d;
        end
    end

    // One restoring step: the remainder stays below the divisor, so the shifted value fits in CNT_W+1 bits.
    assign rem_sh  = rem_q << 1;
    assign rem_ge  = (rem_sh >= {1'b0, divisor_q});
    assign rem_nx  = rem_ge ? (rem_sh - {1'b0, divisor_q}) : rem_sh;
    assign quot_nx = (quot_q << 1) | BIN_BITS'(rem_ge);

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            divisor_q   <= '0;
            sample_q    <= '0;
            quot_q      <= '0;
            step_q      <= '0;
            bin_index_q <= '0;
            bin_phase_q <= '0;
            bin_valid_q <= 1'b0;
        end else if (cfg_ok) begin
            state_q     <= S_IDLE;
            bin_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    rem_q     <= {1'b0, phase_q};
                    divisor_q <= period_q;
                    sample_q  <= phase_q;
                    quot_q    <= '0;
                    step_q    <= '0;
                    state_q   <= S_DIV;
                end
                S_DIV: begin
                    rem_q  <= rem_nx;
                    quot_q <= quot_nx;
                    step_q <= step_q + STEP_W'(1);
                    if (step_q == STEP_LAST) begin
                        state_q     <= S_DONE;
                        bin_index_q <= quot_nx;
                        bin_phase_q <= sample_q;
                        bin_valid_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    bin_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: begin
                    bin_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign clk_out     = clk_out_q;
    assign phase       = phase_q;
    assign bin_index   = bin_index_q;
    assign bin_phase   = bin_phase_q;
    assign bin_valid   = bin_valid_q;
    assign pulse_phase = pulse_phase_q;
    assign pulse_seen  = pulse_seen_q;
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_pulsar_phase_binner.sv
// Bench for pulsar_phase_binner: scenario tasks with inline checks plus a reference-model scoreboard for bin results.
module tb_pulsar_phase_binner;

    localparam int BB = 10;

    typedef struct packed {
        logic [BB-1:0] idx;
        logic [31:0]   ph;
    } exp_t;

    logic          clk_in = 1'b0;
    logic          rst;
    logic          cfg_load;
    logic [31:0]   period_in;
    logic [31:0]   epoch_in;
    logic          resync_en;
    logic          pulse_detected;
    logic          clk_out;
    logic [31:0]   phase;
    logic [BB-1:0] bin_index;
    logic [31:0]   bin_phase;
    logic          bin_valid;
    logic [31:0]   pulse_phase;
    logic          pulse_seen;
    logic          cfg_err;

    int tests_run    = 0;
    int tests_failed = 0;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [31:0] m_phase;
    logic [31:0] m_period;
    logic [31:0] m_nxt;
    int          m_cnt;
    logic        m_valid;
    logic        m_ok;

    pulsar_phase_binner dut (
        .clk_in         (clk_in),
        .rst            (rst),
        .cfg_load       (cfg_load),
        .period_in      (period_in),
        .epoch_in       (epoch_in),
        .resync_en      (resync_en),
        .pulse_detected (pulse_detected),
        .clk_out        (clk_out),
        .phase          (phase),
        .bin_index      (bin_index),
        .bin_phase      (bin_phase),
        .bin_valid      (bin_valid),
        .pulse_phase    (pulse_phase),
        .pulse_seen     (pulse_seen),
        .cfg_err        (cfg_err)
    );

    always #5 clk_in = ~clk_in;

    // Reference model: phase counter and result schedule; expected bins use plain 64-bit arithmetic.
    always @(posedge clk_in or posedge rst) begin
        if (rst) begin
            m_phase  = 32'd0;
            m_period = 32'd1024;
            m_cnt    = 0;
            m_valid  = 1'b0;
            sb_q.delete();
        end else begin
            m_ok    = cfg_load && (period_in != 32'd0) && (epoch_in < period_in);
            m_valid = 1'b0;
            if (m_ok) begin
                if (m_cnt >= 1 && m_cnt <= BB && sb_q.size() > 0) void'(sb_q.pop_back());
                m_cnt = 0;
            end else if (m_cnt == 0) begin
                sb_q.push_back('{idx: BB'(({32'd0, m_phase} << BB) / {32'd0, m_period}), ph: m_phase});
                m_cnt = 1;
            end else if (m_cnt == BB + 1) begin
                m_cnt = 0;
            end else begin
                m_cnt = m_cnt + 1;
                if (m_cnt == BB + 1) m_valid = 1'b1;
            end
            m_nxt = (m_phase == m_period - 32'd1) ? 32'd0 : m_phase + 32'd1;
            if (m_ok) begin
                m_period = period_in;
                m_phase  = (epoch_in == 32'd0) ? 32'd0 : period_in - epoch_in;
            end else if (pulse_detected && !cfg_load && resync_en) begin
                m_phase = 32'd0;
            end else begin
                m_phase = m_nxt;
            end
        end
    end

    always @(negedge clk_in) begin
        if (rst === 1'b0) begin
            tests_run++;
            if (bin_valid !== m_valid) begin
                tests_failed++;
                $display("FAIL sb_valid_timing: bin_valid=%b expected %b at %0t", bin_valid, m_valid, $time);
            end
            if (bin_valid === 1'b1) begin
                tests_run++;
                if (sb_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL sb_unexpected: bin_valid with no pending sample at %0t", $time);
                end else begin
                    mon_e = sb_q.pop_front();
                    if (bin_index !== mon_e.idx || bin_phase !== mon_e.ph) begin
                        tests_failed++;
                        $display("FAIL sb_result: bin_index=%0d bin_phase=%0d expected %0d/%0d",
                                 bin_index, bin_phase, mon_e.idx, mon_e.ph);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (bin_valid !== 1'b1 && n < 40) begin
            @(negedge clk_in);
            n++;
        end
        if (bin_valid !== 1'b1) n = -1;
    endtask

    task automatic load(input logic [31:0] p, input logic [31:0] e);
        cfg_load = 1'b1; period_in = p; epoch_in = e;
        tick(1);
        cfg_load = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(3);
        tests_run++;
        if (phase !== 32'd0 || clk_out !== 1'b0 || bin_valid !== 1'b0 || cfg_err !== 1'b0 || bin_index !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: phase=%0d clk_out=%b bin_valid=%b cfg_err=%b expected all 0", phase, clk_out, bin_valid, cfg_err);
        end
        rst = 1'b0;
        tick(7);
        tests_run++;
        if (clk_out !== 1'b0 || phase !== 32'd7) begin
            tests_failed++;
            $display("FAIL reset_edge7: clk_out=%b phase=%0d expected 0/7", clk_out, phase);
        end
        tick(1);
        tests_run++;
        if (clk_out !== 1'b1) begin tests_failed++; $display("FAIL clkdiv_rise8: clk_out=%b expected 1", clk_out); end
        tick(8);
        tests_run++;
        if (clk_out !== 1'b0) begin tests_failed++; $display("FAIL clkdiv_fall16: clk_out=%b expected 0", clk_out); end
        tick(8);
        tests_run++;
        if (clk_out !== 1'b1) begin tests_failed++; $display("FAIL clkdiv_rise24: clk_out=%b expected 1", clk_out); end
        tick(999);
        tests_run++;
        if (phase !== 32'd1023) begin tests_failed++; $display("FAIL phase_top: phase=%0d expected 1023", phase); end
        tick(1);
        tests_run++;
        if (phase !== 32'd0) begin tests_failed++; $display("FAIL phase_wrap: phase=%0d expected 0", phase); end
    endtask

    task automatic test_bin_values;
        int n;
        load(32'd1000, 32'd0);
        tests_run++;
        if (phase !== 32'd0) begin tests_failed++; $display("FAIL load_epoch0: phase=%0d expected 0", phase); end
        load(32'd1000, 32'd500);
        tests_run++;
        if (phase !== 32'd500) begin tests_failed++; $display("FAIL load_phase500: phase=%0d expected 500", phase); end
        wait_valid(n);
        tests_run++;
        if (n != 11 || bin_index !== 10'd512 || bin_phase !== 32'd500) begin
            tests_failed++;
            $display("FAIL bin_500: latency=%0d idx=%0d ph=%0d expected 11/512/500", n, bin_index, bin_phase);
        end
        tick(1);
        tests_run++;
        if (bin_valid !== 1'b0 || bin_index !== 10'd512) begin
            tests_failed++;
            $display("FAIL bin_hold: bin_valid=%b idx=%0d expected 0/512", bin_valid, bin_index);
        end
        load(32'd1000, 32'd1);
        wait_valid(n);
        tests_run++;
        if (n != 11 || bin_index !== 10'd1022 || bin_phase !== 32'd999) begin
            tests_failed++;
            $display("FAIL bin_999: latency=%0d idx=%0d ph=%0d expected 11/1022/999", n, bin_index, bin_phase);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        tick(1);
        tests_run++;
        if (bin_valid !== 1'b0) begin tests_failed++; $display("FAIL valid_width: bin_valid=%b expected 0", bin_valid); end
        wait_valid(n);
        tests_run++;
        if (n != 11) begin tests_failed++; $display("FAIL throughput: gap=%0d expected 11", n); end
    endtask

    task automatic test_epoch;
        load(32'd1000, 32'd250);
        tests_run++;
        if (phase !== 32'd750) begin tests_failed++; $display("FAIL epoch_750: phase=%0d expected 750", phase); end
        tick(249);
        tests_run++;
        if (phase !== 32'd999) begin tests_failed++; $display("FAIL epoch_999: phase=%0d expected 999", phase); end
        tick(1);
        tests_run++;
        if (phase !== 32'd0) begin tests_failed++; $display("FAIL epoch_wrap: phase=%0d expected 0", phase); end
    endtask

    task automatic test_resync;
        load(32'd1000, 32'd679);
        tests_run++;
        if (phase !== 32'd321) begin tests_failed++; $display("FAIL resync_setup: phase=%0d expected 321", phase); end
        pulse_detected = 1'b1; resync_en = 1'b1;
        tick(1);
        pulse_detected = 1'b0;
        tests_run++;
        if (pulse_phase !== 32'd321 || pulse_seen !== 1'b1 || phase !== 32'd0) begin
            tests_failed++;
            $display("FAIL resync_pulse: pulse_phase=%0d seen=%b phase=%0d expected 321/1/0", pulse_phase, pulse_seen, phase);
        end
        tick(1);
        tests_run++;
        if (pulse_seen !== 1'b0 || phase !== 32'd1) begin
            tests_failed++;
            $display("FAIL resync_after: seen=%b phase=%0d expected 0/1", pulse_seen, phase);
        end
        resync_en = 1'b0; pulse_detected = 1'b1;
        tick(1);
        pulse_detected = 1'b0;
        tests_run++;
        if (pulse_phase !== 32'd1 || pulse_seen !== 1'b1 || phase !== 32'd2) begin
            tests_failed++;
            $display("FAIL noresync: pulse_phase=%0d seen=%b phase=%0d expected 1/1/2", pulse_phase, pulse_seen, phase);
        end
    endtask

    task automatic test_cfg_err;
        int n;
        load(32'd1000, 32'd900);
        load(32'd0, 32'd0);
        tests_run++;
        if (cfg_err !== 1'b1 || phase !== 32'd101) begin
            tests_failed++;
            $display("FAIL reject_p0: cfg_err=%b phase=%0d expected 1/101", cfg_err, phase);
        end
        load(32'd100, 32'd100);
        tests_run++;
        if (cfg_err !== 1'b1 || phase !== 32'd102) begin
            tests_failed++;
            $display("FAIL reject_epoch: cfg_err=%b phase=%0d expected 1/102", cfg_err, phase);
        end
        tick(897);
        tests_run++;
        if (phase !== 32'd999) begin tests_failed++; $display("FAIL period_kept: phase=%0d expected 999", phase); end
        tick(1);
        tests_run++;
        if (phase !== 32'd0) begin tests_failed++; $display("FAIL period_kept_wrap: phase=%0d expected 0", phase); end
        load(32'd1000, 32'd0);
        tests_run++;
        if (cfg_err !== 1'b0) begin tests_failed++; $display("FAIL err_clear: cfg_err=%b expected 0", cfg_err); end
        wait_valid(n);
        tick(4);
        load(32'd1000, 32'd200);
        wait_valid(n);
        tests_run++;
        if (n != 11 || bin_phase !== 32'd800 || bin_index !== 10'd819) begin
            tests_failed++;
            $display("FAIL abort_div: latency=%0d ph=%0d idx=%0d expected 11/800/819", n, bin_phase, bin_index);
        end
    endtask

    task automatic test_period_one;
        int n;
        load(32'd1, 32'd0);
        tick(3);
        tests_run++;
        if (phase !== 32'd0) begin tests_failed++; $display("FAIL period1_phase: phase=%0d expected 0", phase); end
        wait_valid(n);
        tests_run++;
        if (n < 0 || bin_index !== '0 || bin_phase !== 32'd0) begin
            tests_failed++;
            $display("FAIL period1_bin: wait=%0d idx=%0d ph=%0d expected 0/0", n, bin_index, bin_phase);
        end
    endtask

    task automatic test_cfg_pulse_and_reset;
        int n;
        load(32'd1000, 32'd600);
        pulse_detected = 1'b1; resync_en = 1'b0;
        tick(1);
        pulse_detected = 1'b0;
        tests_run++;
        if (pulse_phase !== 32'd400 || phase !== 32'd401) begin
            tests_failed++;
            $display("FAIL pulse_setup: pulse_phase=%0d phase=%0d expected 400/401", pulse_phase, phase);
        end
        cfg_load = 1'b1; period_in = 32'd500; epoch_in = 32'd0; pulse_detected = 1'b1; resync_en = 1'b1;
        tick(1);
        cfg_load = 1'b0; pulse_detected = 1'b0; resync_en = 1'b0;
        tests_run++;
        if (pulse_phase !== 32'd400 || pulse_seen !== 1'b1 || phase !== 32'd0) begin
            tests_failed++;
            $display("FAIL cfg_vs_pulse: pulse_phase=%0d seen=%b phase=%0d expected 400/1/0", pulse_phase, pulse_seen, phase);
        end
        tick(10);
        tests_run++;
        if (phase !== 32'd10) begin tests_failed++; $display("FAIL new_period_count: phase=%0d expected 10", phase); end
        load(32'd0, 32'd0);
        wait_valid(n);
        tick(5);
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (clk_out !== 1'b0 || phase !== 32'd0 || bin_index !== '0 || bin_phase !== 32'd0 || bin_valid !== 1'b0 ||
            pulse_phase !== 32'd0 || pulse_seen !== 1'b0 || cfg_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_div_reset: clk_out=%b phase=%0d idx=%0d bph=%0d vld=%b pph=%0d seen=%b err=%b expected all 0",
                     clk_out, phase, bin_index, bin_phase, bin_valid, pulse_phase, pulse_seen, cfg_err);
        end
        tick(2);
        rst = 1'b0;
        tick(30);
    endtask

    initial begin
        rst = 1'b1; cfg_load = 1'b0; period_in = 32'd0; epoch_in = 32'd0;
        resync_en = 1'b0; pulse_detected = 1'b0;
        test_reset();
        test_bin_values();
        test_back_to_back();
        test_epoch();
        test_resync();
        test_cfg_err();
        test_period_one();
        test_cfg_pulse_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
